xor_multiport_memory: RTL and testbench
=======================================

Name: xor_multiport_memory

Overview:
- Parametrised successor to the team's XOR-coded BRAM multiport memory.
- Provides W independent write ports and R independent read ports over a bank array of simple_dual_port_memory_wrapper instances.
- Adds synchronous reset, a post-reset memory-clear sweep, read-valid tracking, same-address bypass for back-to-back writes and reads, and detection of same-cycle write conflicts.
- Sits in the memory subsystem as a drop-in for any multi-writer table.

Parameters:
- WIDTH, 32, data bits per word
- DEPTH, 1024, words; AW = $clog2(DEPTH)
- WRITE_PORTS, 4, number of write ports W (>=1)
- READ_PORTS, 4, number of read ports R (>=1)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  [W]  write request per port
- wr_addr  in  [W][AW]  write address
- wr_data  in  [W][WIDTH]  write data
- rd_en  in  [R]  read request per port
- rd_addr  in  [R][AW]  read address
- rd_data  out  [R][WIDTH]  read data
- rd_valid  out  [R]  rd_data valid
- ready  out  1  clear sweep done; requests accepted
- wr_conflict  out  1  sticky same-cycle same-address write error

Behaviour:
- Reset: one clock with rst_n=0 at the rising edge forces the state to CLEAR and sets clr_addr=0, ready=0, rd_valid=0, rd_data=0, wr_conflict=0, and all pipeline valids to 0.
- Reset mid-operation: in-flight writes and reads are discarded; the sweep restarts from address 0.
- FSM, CLEAR: each cycle writes 0 at clr_addr into every bank, then increments clr_addr. At clr_addr==DEPTH-1 the FSM goes to RUN.
- FSM, RUN: ready=1 from the edge after the last clear write. The clear takes exactly DEPTH cycles after reset deasserts.
- While ready=0: wr_en and rd_en are ignored and rd_valid stays 0.
- Bank structure: row i belongs to write port i.
  - Columns j≠i (W-1 of them) feed the feedback reads of the other writers.
  - R further columns serve the read ports.
  - Every bank in row i is written with the same data at the same address.
- Write pipeline:
  - S1 (edge t): register wr_en/addr/data. In the same cycle, issue feedback reads at wr_addr on row k, column i, for every k≠i.
  - S2 (edge t+1): row i is written with wr_data_i ^ XOR over k≠i of feedback_k.
  - Stored word = XOR of all rows at that address.
- Write bypass: if S2 of port k commits address A while S1 of port i has feedback address A, port i uses port k's S2 write word in place of the RAM output for row k. Result: back-to-back writes to the same address from different ports serialise correctly.
- Read latency: rd_addr is sampled at edge t. Read p XORs row outputs (column W-1+p) and registers the result. rd_data and rd_valid appear after edge t+2; rd_valid=0 in cycles where no read was issued two edges earlier.
- Read ordering:
  - Read issued in the same cycle as a write to the same address returns the old word.
  - Read issued one cycle later returns the new word; the read bypass substitutes the S2 row word.
  - Reads issued two or more cycles later return the new word directly from RAM.
- Same-cycle write conflict: two or more enabled writes to the same address in one cycle. The lowest-index port wins; the others are dropped and wr_conflict is set and held until reset.
- rd_data holds its last value when rd_valid=0.
- Widths: all XOR is WIDTH bits, with no truncation or extension.

Decomposition:
- Package xor_mpm_pkg:
  - state enum {CLEAR, RUN};
  - localparam RD_LATENCY=2;
  - localparam WR_COMMIT_LATENCY=1.
- Address and data types are parameter-dependent and stay in the module.
- Reuse the existing simple_dual_port_memory_wrapper as the bank primitive; no other sub-module.
- Optional helper function xor_reduce in the package.

Test Plan:
- Reset with DEPTH=16: rst_n low for 1 cycle -> ready=0 for exactly 16 cycles, then 1. Read of each of 16 addresses -> 0, with rd_valid 2 cycles after each rd_en.
- W=4, R=4: port0 writes 0xDEADBEEF to address 5 at cycle t; read port 2 reads address 5 at t+2 -> rd_data[2]=0xDEADBEEF at t+4.
- Port1 writes 0x11 to address 7 at t, port3 writes 0x22 to address 7 at t+1, read at t+3 -> 0x22. Repeat with the order swapped -> 0x11 (checks the write bypass).
- Write 0xAA to address 3 at t after a prior value of 0x55. Reads of address 3 issued at t -> 0x55; at t+1 -> 0xAA; at t+2 -> 0xAA.
- Ports 0 and 2 both write address 9 (0x1, 0x2) in the same cycle -> wr_conflict=1 the next cycle and stays 1; a later read -> 0x1. Reset clears wr_conflict.
- Reset asserted mid-stream, with writes in S1 and S2 and reads in flight -> rd_valid=0 immediately, a full clear sweep, and all addresses reading 0 afterwards.

Source files
------------

// File: rtl/xor_mpm_pkg.sv
// Shared types and latency constants for the XOR-coded multiport memory.
package xor_mpm_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int RD_LATENCY        = 2;
    localparam int WR_COMMIT_LATENCY = 1;

endpackage

// File: rtl/simple_dual_port_memory_wrapper.sv
// One-write/one-read bank primitive with a registered, read-first read port
// (a read and a write to the same address on one edge returns the old word).
module simple_dual_port_memory_wrapper #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Array write and registered read; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/xor_multiport_memory.sv
// W-write / R-read memory built from 1W1R banks: row i holds write port i's
// share, and the stored word is the XOR of all rows at an address.
module xor_multiport_memory
    import xor_mpm_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 1024,
    parameter int WRITE_PORTS = 4,
    parameter int READ_PORTS  = 4,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [WRITE_PORTS-1:0]                 wr_en_i,
    input  logic [WRITE_PORTS-1:0][AW-1:0]         wr_addr_i,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]      wr_data_i,
    input  logic [READ_PORTS-1:0]                  rd_en_i,
    input  logic [READ_PORTS-1:0][AW-1:0]          rd_addr_i,
    output logic [READ_PORTS-1:0][WIDTH-1:0]       rd_data_o,
    output logic [READ_PORTS-1:0]                  rd_valid_o,
    output logic                                   ready_o,
    output logic                                   wr_conflict_o
);

    localparam int W = WRITE_PORTS;
    localparam int R = READ_PORTS;

    state_e                    state_q, state_d;
    logic [AW-1:0]             clr_addr_q, clr_addr_d;
    logic                      ready_q, ready_d;
    logic                      wr_conflict_q;

    logic [W-1:0]              dup_s;
    logic [W-1:0]              wr_ok_s;
    logic                      conflict_s;

    logic [W-1:0]              s1_en_q;
    logic [W-1:0][AW-1:0]      s1_addr_q;
    logic [W-1:0][WIDTH-1:0]   s1_data_q;
    logic [W-1:0]              s2_en_q;
    logic [W-1:0][AW-1:0]      s2_addr_q;
    logic [W-1:0][WIDTH-1:0]   s2_word_q;
    logic [W-1:0][WIDTH-1:0]   row_word_s;

    logic [W-1:0]              bank_we_s;
    logic [W-1:0][AW-1:0]      bank_waddr_s;
    logic [W-1:0][WIDTH-1:0]   bank_wdata_s;
    logic [WIDTH-1:0]          fb_rdata_s [W][W];
    logic [WIDTH-1:0]          rb_rdata_s [W][R];

    logic [R-1:0]              rd1_en_q;
    logic [R-1:0][AW-1:0]      rd1_addr_q;
    logic [R-1:0][WIDTH-1:0]   rd_x_s;
    logic [R-1:0]              rd2_en_q;
    logic [R-1:0][WIDTH-1:0]   rd2_data_q;
    logic [R-1:0]              rd_valid_q;
    logic [R-1:0][WIDTH-1:0]   rd_data_q;

    // Clear-sweep FSM: one zero write per cycle, RUN after the last address.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ready_d    = ready_q;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d    = RUN;
                    ready_d    = 1'b1;
                    clr_addr_d = '0;
                end else begin
                    state_d    = CLEAR;
                    ready_d    = 1'b0;
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            RUN: begin
                state_d = RUN;
                ready_d = 1'b1;
            end
            default: begin
                state_d    = CLEAR;
                ready_d    = 1'b0;
                clr_addr_d = '0;
            end
        endcase
    end

    // Same-address arbitration: a port loses to any lower-index port on its address.
    always_comb begin
        dup_s      = '0;
        wr_ok_s    = '0;
        conflict_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < i; j++) begin
                dup_s[i] = dup_s[i] | (wr_en_i[j] & (wr_addr_i[j] == wr_addr_i[i]));
            end
            wr_ok_s[i] = wr_en_i[i] & ready_q & ~dup_s[i];
            conflict_s = conflict_s | (wr_en_i[i] & ready_q & dup_s[i]);
        end
    end

    // Row word = new data XOR the other rows; a row still being committed is
    // taken from its S2 register because the bank read saw the old value.
    always_comb begin
        row_word_s = '0;
        for (int i = 0; i < W; i++) begin
            row_word_s[i] = s1_data_q[i];
            for (int k = 0; k < W; k++) begin
                row_word_s[i] = row_word_s[i] ^
                    (((k != i) && s2_en_q[k] && (s2_addr_q[k] == s1_addr_q[i])) ?
                     s2_word_q[k] : fb_rdata_s[k][i]);
            end
        end
    end

    // Bank write selection: zero sweep while clearing, otherwise the S1 commit.
    always_comb begin
        bank_we_s    = '0;
        bank_waddr_s = '0;
        bank_wdata_s = '0;
        for (int i = 0; i < W; i++) begin
            bank_we_s[i]    = (state_q == CLEAR) | s1_en_q[i];
            bank_waddr_s[i] = (state_q == CLEAR) ? clr_addr_q : s1_addr_q[i];
            bank_wdata_s[i] = (state_q == CLEAR) ? {WIDTH{1'b0}} : row_word_s[i];
        end
    end

    // Read combine with the same S2 bypass as the feedback path.
    always_comb begin
        rd_x_s = '0;
        for (int p = 0; p < R; p++) begin
            for (int k = 0; k < W; k++) begin
                rd_x_s[p] = rd_x_s[p] ^
                    ((s2_en_q[k] && (s2_addr_q[k] == rd1_addr_q[p])) ?
                     s2_word_q[k] : rb_rdata_s[k][p]);
            end
        end
    end

    for (genvar gk = 0; gk < W; gk++) begin : g_row
        for (genvar gi = 0; gi < W; gi++) begin : g_fb
            if (gi != gk) begin : g_bank
                simple_dual_port_memory_wrapper #(
                    .WIDTH (WIDTH),
                    .DEPTH (DEPTH),
                    .AW    (AW)
                ) u_bank (
                    .clk       (clk),
                    .wr_en_i   (bank_we_s[gk]),
                    .wr_addr_i (bank_waddr_s[gk]),
                    .wr_data_i (bank_wdata_s[gk]),
                    .rd_addr_i (wr_addr_i[gi]),
                    .rd_data_o (fb_rdata_s[gk][gi])
                );
            end else begin : g_self
                assign fb_rdata_s[gk][gi] = {WIDTH{1'b0}};
            end
        end
        for (genvar gp = 0; gp < R; gp++) begin : g_rd
            simple_dual_port_memory_wrapper #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_bank (
                .clk       (clk),
                .wr_en_i   (bank_we_s[gk]),
                .wr_addr_i (bank_waddr_s[gk]),
                .wr_data_i (bank_wdata_s[gk]),
                .rd_addr_i (rd_addr_i[gp]),
                .rd_data_o (rb_rdata_s[gk][gp])
            );
        end
    end

    // Control, valids and sticky conflict flag; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= CLEAR;
            clr_addr_q    <= '0;
            ready_q       <= 1'b0;
            wr_conflict_q <= 1'b0;
            s1_en_q       <= '0;
            s2_en_q       <= '0;
            rd1_en_q      <= '0;
            rd2_en_q      <= '0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            ready_q       <= ready_d;
            wr_conflict_q <= wr_conflict_q | conflict_s;
            s1_en_q       <= wr_ok_s;
            s2_en_q       <= s1_en_q;
            rd1_en_q      <= rd_en_i & {R{ready_q}};
            rd2_en_q      <= rd1_en_q;
            rd_valid_q    <= rd2_en_q;
            for (int p = 0; p < R; p++) begin
                if (rd2_en_q[p]) begin
                    rd_data_q[p] <= rd2_data_q[p];
                end
            end
        end
    end

    // Address/data pipeline registers, qualified by the valids above.
    always_ff @(posedge clk) begin
        s1_addr_q  <= wr_addr_i;
        s1_data_q  <= wr_data_i;
        s2_addr_q  <= s1_addr_q;
        s2_word_q  <= row_word_s;
        rd1_addr_q <= rd_addr_i;
        rd2_data_q <= rd_x_s;
    end

    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign ready_o       = ready_q;
    assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_xor_multiport_memory.sv
// Directed bench for xor_multiport_memory at DEPTH=16, four write and four read ports.
module tb_xor_multiport_memory;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int W     = 4;
    localparam int R     = 4;
    localparam int AW    = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [W-1:0]               wr_en;
    logic [W-1:0][AW-1:0]       wr_addr;
    logic [W-1:0][WIDTH-1:0]    wr_data;
    logic [R-1:0]               rd_en;
    logic [R-1:0][AW-1:0]       rd_addr;
    logic [R-1:0][WIDTH-1:0]    rd_data;
    logic [R-1:0]               rd_valid;
    logic                       ready;
    logic                       wr_conflict;

    int tests_run    = 0;
    int tests_failed = 0;

    xor_multiport_memory #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .WRITE_PORTS (W),
        .READ_PORTS  (R),
        .AW          (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .rd_en_i       (rd_en),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .ready_o       (ready),
        .wr_conflict_o (wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = '0;
        rd_en = '0;
    endtask

    task automatic write1(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[p]   = 1'b1;
        wr_addr[p] = a;
        wr_data[p] = d;
    endtask

    // Single read on port p: valid must be low one cycle early, high at latency two.
    task automatic read_check(input string tag, input int p, input logic [AW-1:0] a,
                              input logic [31:0] exp);
        rd_en[p]   = 1'b1;
        rd_addr[p] = a;
        step();
        rd_en[p] = 1'b0;
        step();
        check_eq({tag, "_early"}, 32'(rd_valid[p]), 32'd0);
        step();
        check_eq({tag, "_valid"}, 32'(rd_valid[p]), 32'd1);
        check_eq(tag, rd_data[p], exp);
    endtask

    task automatic reset_and_sweep(input string tag);
        int n;
        rst_n = 1'b0;
        idle();
        step();
        check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check_eq({tag, "_ready"}, 32'(ready), 32'd0);
        check_eq({tag, "_conflict"}, 32'(wr_conflict), 32'd0);
        for (int p = 0; p < R; p++) begin
            check_eq({tag, "_rd_data"}, rd_data[p], 32'd0);
        end
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            n++;
            step();
        end
        check_eq({tag, "_clear_cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        step();
        step();

        reset_and_sweep("rst0");
        for (int a = 0; a < DEPTH; a++) begin
            read_check("clr_rd", a % 4, 4'(a), 32'd0);
        end

        // Basic write then read on another port.
        write1(0, 4'd5, 32'hDEAD_BEEF);
        step();
        idle();
        step();
        read_check("beef", 2, 4'd5, 32'hDEAD_BEEF);

        // Back-to-back writes from different ports to one address.
        write1(1, 4'd7, 32'h11);
        step();
        idle();
        write1(3, 4'd7, 32'h22);
        step();
        idle();
        step();
        read_check("bypass_1_3", 0, 4'd7, 32'h22);
        write1(3, 4'd7, 32'h22);
        step();
        idle();
        write1(1, 4'd7, 32'h11);
        step();
        idle();
        step();
        read_check("bypass_3_1", 1, 4'd7, 32'h11);

        // Read ordering around a write: old, then new via bypass, then new from RAM.
        write1(1, 4'd3, 32'h55);
        step();
        idle();
        step();
        step();
        step();
        write1(0, 4'd3, 32'hAA);
        rd_en[0]   = 1'b1;
        rd_addr[0] = 4'd3;
        step();
        wr_en = '0;
        step();
        step();
        rd_en = '0;
        check_eq("order_t0_valid", 32'(rd_valid[0]), 32'd1);
        check_eq("order_t0", rd_data[0], 32'h55);
        step();
        check_eq("order_t1", rd_data[0], 32'hAA);
        step();
        check_eq("order_t2", rd_data[0], 32'hAA);
        step();
        check_eq("order_idle_valid", 32'(rd_valid[0]), 32'd0);
        check_eq("order_hold", rd_data[0], 32'hAA);

        // Same-cycle write conflict: port 0 wins, flag is sticky.
        check_eq("no_conflict_yet", 32'(wr_conflict), 32'd0);
        write1(0, 4'd9, 32'h1);
        write1(2, 4'd9, 32'h2);
        step();
        idle();
        check_eq("conflict_set", 32'(wr_conflict), 32'd1);
        step();
        step();
        check_eq("conflict_sticky", 32'(wr_conflict), 32'd1);
        read_check("conflict_rd", 1, 4'd9, 32'h1);
        check_eq("conflict_still", 32'(wr_conflict), 32'd1);

        // Fill memory, then reset with writes and reads in flight.
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            write1(a % 4, 4'(a), 32'hA0 + 32'(a));
            step();
        end
        idle();
        step();
        read_check("fill", 0, 4'd10, 32'hAA);
        write1(1, 4'd2, 32'h77);
        rd_en[1]   = 1'b1;
        rd_addr[1] = 4'd2;
        step();
        idle();
        write1(2, 4'd4, 32'h88);
        rd_en[3]   = 1'b1;
        rd_addr[3] = 4'd4;
        step();
        reset_and_sweep("rst_mid");
        for (int a = 0; a < DEPTH; a++) begin
            read_check("mid_clr_rd", (a + 1) % 4, 4'(a), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
